// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and processor status.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RAX    = 4'h0;
  localparam logic [3:0] R_RCX    = 4'h1;
  localparam logic [3:0] R_RDX    = 4'h2;
  localparam logic [3:0] R_RBX    = 4'h3;
  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_RBP    = 4'h5;
  localparam logic [3:0] R_RSI    = 4'h6;
  localparam logic [3:0] R_RDI    = 4'h7;
  localparam logic [3:0] R_R8     = 4'h8;
  localparam logic [3:0] R_R9     = 4'h9;
  localparam logic [3:0] R_R10    = 4'hA;
  localparam logic [3:0] R_R11    = 4'hB;
  localparam logic [3:0] R_R12    = 4'hC;
  localparam logic [3:0] R_R13    = 4'hD;
  localparam logic [3:0] R_R14    = 4'hE;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam int NUM_REGS = 15;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_t;

endpackage

// File: rtl/y86_stat_fsm.sv
// Sticky processor status FSM; also decides whether the presented instruction commits.
module y86_stat_fsm
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid_i,
  input  logic [3:0] icode_i,
  input  logic       instr_valid_i,
  input  logic       mem_err_i,
  output logic [1:0] stat_o,
  output logic       halted_o,
  output logic       commit_o
);

  stat_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STAT_AOK;
    end else begin
      state_q <= state_d;
    end
  end

  // Any non-AOK state is terminal; a halt instruction still commits.
  always_comb begin
    state_d  = state_q;
    commit_o = 1'b0;
    if (state_q == STAT_AOK && wb_valid_i) begin
      if (mem_err_i) begin
        state_d = STAT_ADR;
      end else if (!instr_valid_i) begin
        state_d = STAT_INS;
      end else begin
        commit_o = 1'b1;
        if (icode_i == I_HALT) begin
          state_d = STAT_HLT;
        end
      end
    end
  end

  assign stat_o   = state_q;
  assign halted_o = (state_q != STAT_AOK);

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and 15-entry register file with status and retire counter.
// Define WB_BYPASS_EN for write-through reads of the value being committed this cycle.
module writeback_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        mem_err,
  input  logic [3:0]  dstE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA_rd,
  output logic [63:0] valB_rd,
  output logic [1:0]  stat,
  output logic        halted,
  output logic [63:0] retired
);

  logic        commit;
  logic [63:0] reg_q [NUM_REGS];
  logic [63:0] reg_d [NUM_REGS];
  logic [63:0] retired_q, retired_d;

  y86_stat_fsm u_stat_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid_i    (wb_valid),
    .icode_i       (icode),
    .instr_valid_i (instr_valid),
    .mem_err_i     (mem_err),
    .stat_o        (stat),
    .halted_o      (halted),
    .commit_o      (commit)
  );

  // valM is tested first so that dstE == dstM resolves to the memory value (popq %rsp).
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_next
    assign reg_d[gi] = (commit && dstM == 4'(gi)) ? valM :
                       (commit && dstE == 4'(gi)) ? valE : reg_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  assign retired_d = commit ? retired_q + 64'd1 : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  function automatic logic [63:0] read_port(input logic [3:0] addr);
    logic [63:0] data;
    data = '0;
    if (addr != REG_NONE) begin
      data = reg_q[addr];
`ifdef WB_BYPASS_EN
      if (commit && dstE == addr) begin
        data = valE;
      end
      if (commit && dstM == addr) begin
        data = valM;
      end
`endif
    end
    return data;
  endfunction

  assign valA_rd = read_port(srcA);
  assign valB_rd = read_port(srcB);

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized self-checking bench for writeback_regfile against an architectural model.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        mem_err;
  logic [3:0]  dstE, dstM;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA_rd, valB_rd;
  logic [1:0]  stat;
  logic        halted;
  logic [63:0] retired;

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: 16 slots, slot 15 permanently zero ("no register").
  logic [63:0] reg_m [16] = '{default: '0};
  logic [1:0]  stat_m = 2'd0;
  logic [63:0] retired_m = '0;

  writeback_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .icode       (icode),
    .instr_valid (instr_valid),
    .mem_err     (mem_err),
    .dstE        (dstE),
    .dstM        (dstM),
    .valE        (valE),
    .valM        (valM),
    .srcA        (srcA),
    .srcB        (srcB),
    .valA_rd     (valA_rd),
    .valB_rd     (valB_rd),
    .stat        (stat),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit commit_now();
    return wb_valid && stat_m == 2'd0 && !mem_err && instr_valid;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [3:0] a);
    if (a == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
    if (commit_now()) begin
      if (dstM == a) return valM;
      if (dstE == a) return valE;
    end
`endif
    return reg_m[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) reg_m[i] = '0;
      stat_m = 2'd0;
      retired_m = '0;
    end else begin
      if (commit_now()) begin
        if (dstE != 4'hF) reg_m[dstE] = valE;
        if (dstM != 4'hF) reg_m[dstM] = valM;
        retired_m = retired_m + 64'd1;
      end
      if (wb_valid && stat_m == 2'd0) begin
        if (mem_err)           stat_m = 2'd2;
        else if (!instr_valid) stat_m = 2'd3;
        else if (icode == 4'h0) stat_m = 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("valA_rd", valA_rd, exp_rd(srcA));
    check("valB_rd", valB_rd, exp_rd(srcB));
    check("stat", {62'd0, stat}, {62'd0, stat_m});
    check("halted", {63'd0, halted}, {63'd0, (stat_m != 2'd0)});
    check("retired", retired, retired_m);
  end

  task automatic idle();
    wb_valid = 1'b0; icode = 4'h1; instr_valid = 1'b1; mem_err = 1'b0;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
  endtask

  task automatic apply(input logic [3:0] ic, input logic iv, input logic me,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    wb_valid = 1'b1; icode = ic; instr_valid = iv; mem_err = me;
    dstE = de; dstM = dm; valE = ve; valM = vm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs before any edge.
  task automatic do_reset();
    idle();
    srcA = 4'($urandom_range(0, 14));
    srcB = 4'($urandom_range(0, 14));
    #2 rst_n = 1'b0;
    #1;
    check("rst_valA", valA_rd, 64'd0);
    check("rst_valB", valB_rd, 64'd0);
    check("rst_stat", {62'd0, stat}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_retired", retired, 64'd0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    srcA = 4'hF; srcB = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write to %rbx
    apply(4'h3, 1'b1, 1'b0, 4'h3, 4'hF, 64'h1234, 64'h0);
    srcA = 4'h3; srcB = 4'hF;
    next_cycle(); idle();
    check("wr_r3", valA_rd, 64'h1234);
    check("rd_none", valB_rd, 64'd0);
    check("ret_1", retired, 64'd1);

    // dstE == dstM: memory value wins
    apply(4'hB, 1'b1, 1'b0, 4'h4, 4'h4, 64'h100, 64'h55);
    srcA = 4'h4;
    next_cycle(); idle();
    check("popq_r4", valA_rd, 64'h55);
    check("ret_2", retired, 64'd2);

    // Same-cycle read of a register being written
    apply(4'h3, 1'b1, 1'b0, 4'h5, 4'hF, 64'hAA, 64'h0);
    srcB = 4'h5;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_pre", valB_rd, 64'hAA);
`else
    check("bypass_pre", valB_rd, 64'h0);
`endif
    next_cycle(); idle();
    check("r5_post", valB_rd, 64'hAA);
    check("ret_3", retired, 64'd3);

    // Address fault blocks its own write and all later ones
    apply(4'h5, 1'b1, 1'b1, 4'h2, 4'hF, 64'h7, 64'h0);
    srcA = 4'h2;
    next_cycle(); idle();
    check("adr_stat", {62'd0, stat}, 64'd2);
    check("adr_halted", {63'd0, halted}, 64'd1);
    check("adr_r2", valA_rd, 64'd0);
    check("adr_ret", retired, 64'd3);
    apply(4'h3, 1'b1, 1'b0, 4'h2, 4'hF, 64'h9, 64'h0);
    next_cycle(); idle();
    check("blk_r2", valA_rd, 64'd0);
    check("blk_ret", retired, 64'd3);
    check("blk_stat", {62'd0, stat}, 64'd2);

    // mem_err beats instr_valid=0
    do_reset();
    apply(4'h3, 1'b0, 1'b1, 4'h1, 4'hF, 64'h1, 64'h0);
    next_cycle(); idle();
    check("prio_stat", {62'd0, stat}, 64'd2);

    // Halt commits once, then wb_valid is ignored
    do_reset();
    apply(4'h0, 1'b1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
    next_cycle(); idle();
    check("hlt_stat", {62'd0, stat}, 64'd1);
    check("hlt_halted", {63'd0, halted}, 64'd1);
    check("hlt_ret", retired, 64'd1);
    apply(4'h3, 1'b1, 1'b0, 4'h1, 4'hF, 64'h77, 64'h0);
    srcA = 4'h1;
    next_cycle(); idle();
    check("hlt_r1", valA_rd, 64'd0);
    check("hlt_ret2", retired, 64'd1);

    // Random episodes, each started by a mid-cycle reset
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        wb_valid    = ($urandom_range(0, 3) != 0);
        icode       = ($urandom_range(0, 199) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
        mem_err     = ($urandom_range(0, 199) == 0);
        instr_valid = ($urandom_range(0, 199) != 0);
        dstE        = 4'($urandom_range(0, 15));
        dstM        = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
        valE        = {$urandom, $urandom};
        valM        = {$urandom, $urandom};
        srcA        = 4'($urandom_range(0, 15));
        srcB        = ($urandom_range(0, 2) == 0) ? dstE : 4'($urandom_range(0, 15));
        next_cycle();
      end
    end

    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
